matmul_sched: RTL and testbench

- Job scheduler and arbiter for the shared 4x4 matmul engine.
- Up to NREQ requesters (DMA/firmware stream sources) each want one 32-word job: A then B, row-major.
- The block grants one requester at a time round-robin, pulses the engine start, and muxes the granted stream into the engine's AXI-stream slave.
- It then counts the 16 result writes, detects completion or timeout, and reports per-requester done plus error status.

---
 rtl/matmul_sched.sv | 190 +++++++++++++++++++
 tb/tb_matmul_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sched.sv
// matmul_sched: round-robin job scheduler in front of the shared 4x4 matmul
// engine. A granted requester streams its 32-word job (A then B) through to
// the engine. The block then counts result writes and reports done/error.
// Optional macro SCHED_PERF_EN adds a START-to-DONE latency counter on
// perf_cycles. Without it, perf_cycles is tied to zero.
module matmul_sched #(
    parameter int NREQ      = 2,
    parameter int IN_WORDS  = 32,
    parameter int OUT_WORDS = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_grant,
    output logic [NREQ-1:0]      req_done,
    input  logic [NREQ-1:0]      s_tvalid,
    input  logic [NREQ*32-1:0]   s_tdata,
    input  logic [NREQ-1:0]      s_tlast,
    output logic [NREQ-1:0]      s_tready,
    output logic                 m_tvalid,
    output logic [31:0]          m_tdata,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic                 ap_start_matmul,
    input  logic                 w_fifo_en,
    input  logic                 done_matmul,
    output logic                 busy,
    output logic [2:0]           err_code,
    output logic [31:0]          perf_cycles
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(IN_WORDS + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   gidx_reg;
    logic [BW-1:0]   beat_reg;
    logic [4:0]      wr_reg;
    logic [CW-1:0]   cyc_reg;

    logic            pick_any;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic            feed;
    logic            beat_fire;
    logic            last_beat;
    logic [4:0]      wr_inc;

    // Round-robin search: first pending requester at or above ptr, wrapping.
    // Iterating downward lets the closest candidate overwrite farther ones.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_reg) + k) % NREQ]) begin
                pick_any = 1'b1;
                pick_idx = PW'((int'(ptr_reg) + k) % NREQ);
            end
        end
    end

    assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;

    // Stream mux. It is open only in FEED, so the engine never sees a beat
    // outside the job window. Beat IN_WORDS moves the state to WAIT on the
    // same edge, so an extra beat is never accepted.
    assign feed      = (state_reg == FEED);
    assign m_tvalid  = feed & s_tvalid[gidx_reg];
    assign m_tdata   = feed ? s_tdata[int'(gidx_reg)*32 +: 32] : 32'd0;
    assign m_tlast   = feed & s_tlast[gidx_reg];
    assign beat_fire = m_tvalid & m_tready;
    assign last_beat = (beat_reg == BW'(IN_WORDS - 1));

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign s_tready[gi] = feed && (gidx_reg == PW'(gi)) && m_tready;
        end
    endgenerate

    // Result-write count including this cycle's strobe, saturating at 31.
    // A done pulse therefore also counts a strobe that arrives with it.
    assign wr_inc = (w_fifo_en && (wr_reg != 5'd31)) ? wr_reg + 5'd1 : wr_reg;

    // Job sequencing FSM with registered grant/start/done/busy/error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            gidx_reg        <= '0;
            beat_reg        <= '0;
            wr_reg          <= '0;
            cyc_reg         <= '0;
            req_grant       <= '0;
            req_done        <= '0;
            ap_start_matmul <= 1'b0;
            busy            <= 1'b0;
            err_code        <= '0;
        end else begin
            ap_start_matmul <= 1'b0;
            req_done        <= '0;
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        state_reg       <= START;
                        gidx_reg        <= pick_idx;
                        req_grant       <= pick_onehot;
                        err_code        <= '0;
                        beat_reg        <= '0;
                        wr_reg          <= '0;
                        cyc_reg         <= '0;
                        ap_start_matmul <= 1'b1;
                        busy            <= 1'b1;
                    end
                end
                START: begin
                    state_reg <= FEED;
                end
                FEED: begin
                    if (beat_fire) begin
                        beat_reg <= beat_reg + BW'(1);
                        // tlast must appear exactly on the final beat.
                        if (m_tlast != last_beat) begin
                            err_code[0] <= 1'b1;
                        end
                        if (last_beat) begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wr_reg <= wr_inc;
                    if (done_matmul) begin
                        if (wr_inc != 5'(OUT_WORDS)) begin
                            err_code[1] <= 1'b1;
                        end
                        state_reg <= DONE;
                        req_done  <= req_grant;
                    end else if (cyc_reg == CW'(TIMEOUT - 1)) begin
                        err_code[2] <= 1'b1;
                        state_reg   <= DONE;
                        req_done    <= req_grant;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    req_grant <= '0;
                    busy      <= 1'b0;
                    ptr_reg   <= (gidx_reg == PW'(NREQ - 1)) ? '0 : gidx_reg + PW'(1);
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_PERF_EN
    logic [31:0] perf_cnt_reg;

    // Latency counter: the cycles from START through DONE inclusive, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_reg <= '0;
            perf_cycles  <= '0;
        end else if (state_reg == IDLE) begin
            perf_cnt_reg <= '0;
        end else if (state_reg == DONE) begin
            perf_cycles <= (perf_cnt_reg == 32'hFFFF_FFFF) ? perf_cnt_reg : perf_cnt_reg + 32'd1;
        end else begin
            perf_cnt_reg <= (perf_cnt_reg == 32'hFFFF_FFFF) ? perf_cnt_reg : perf_cnt_reg + 32'd1;
        end
    end
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_sched.sv
// Directed testbench for matmul_sched (NREQ=2, 32 in / 16 out, TIMEOUT=1024).
module tb_matmul_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_grant;
    logic [1:0]   req_done;
    logic [1:0]   s_tvalid = '0;
    logic [63:0]  s_tdata = '0;
    logic [1:0]   s_tlast = '0;
    logic [1:0]   s_tready;
    logic         m_tvalid;
    logic [31:0]  m_tdata;
    logic         m_tlast;
    logic         m_tready = 1'b1;
    logic         ap_start_matmul;
    logic         w_fifo_en = 1'b0;
    logic         done_matmul = 1'b0;
    logic         busy;
    logic [2:0]   err_code;
    logic [31:0]  perf_cycles;

    int checks = 0;
    int errors = 0;

    matmul_sched #(
        .NREQ(2), .IN_WORDS(32), .OUT_WORDS(16), .TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_grant(req_grant), .req_done(req_done),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
        .ap_start_matmul(ap_start_matmul), .w_fifo_en(w_fifo_en), .done_matmul(done_matmul),
        .busy(busy), .err_code(err_code), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    // Passive observers, sampled on the falling edge between input updates.
    logic [31:0] rx_q[$];
    int starts = 0, dones = 0, multi = 0, busy_cyc = 0;
    always @(negedge clk) begin
        if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
        if (ap_start_matmul) starts++;
        if (req_done != 2'b00) dones++;
        if ($countones(req_grant) > 1) multi++;
        if (busy) busy_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int s, input int b);
        return 32'hC0DE_0000 | (s << 8) | b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Source side: present beats 1..nbeats of requester src, with optional
    // source bubbles and a 5-cycle engine back-pressure window.
    task automatic feed(input int src, input int nbeats, input int tlast_beat,
                        input bit stall_src, input bit stall_eng, output int sent);
        int cyc = 0;
        sent = 0;
        while (sent < nbeats && cyc < 400) begin
            s_tvalid = '0;
            s_tlast  = '0;
            if (!stall_src || (cyc % 2) == 0) s_tvalid[src] = 1'b1;
            s_tdata[src*32 +: 32] = pat(src, sent + 1);
            s_tlast[src] = ((sent + 1) == tlast_beat);
            m_tready = !(stall_eng && cyc >= 4 && cyc < 9);
            #1;
            if (s_tvalid[src] && s_tready[src]) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
    endtask

    // Engine side: nwr result strobes, optionally merging the last with done.
    task automatic engine(input int nwr, input bit last_with_done, input bit give_done);
        int plain = (last_with_done && give_done) ? nwr - 1 : nwr;
        for (int i = 0; i < plain; i++) begin
            w_fifo_en = 1'b1;
            tick();
            w_fifo_en = 1'b0;
            tick();
        end
        if (give_done) begin
            done_matmul = 1'b1;
            w_fifo_en   = last_with_done;
            tick();
            done_matmul = 1'b0;
            w_fifo_en   = 1'b0;
        end
    endtask

    task automatic run_job(input string name, input logic [1:0] rv, input int src,
                           input int tlast_beat, input bit ss, input bit se,
                           input int nwr, input bit lwd, input bit gd,
                           input logic [2:0] exp_err, input int exp_wait);
        int base = rx_q.size();
        int st0 = starts, dn0 = dones, bz0 = busy_cyc;
        int n = 0, sent = 0, bad = 0, got = 0;
        logic [1:0] exp_g = 2'b01 << src;
        req_valid = rv;
        while (req_grant == 2'b00 && n < 20) begin tick(); n++; end
        chk({name, "_grant"}, req_grant, exp_g);
        chk({name, "_start"}, ap_start_matmul, 1'b1);
        chk({name, "_busy"}, busy, 1'b1);
        chk({name, "_errclr"}, err_code, 3'b000);
        feed(src, 32, tlast_beat, ss, se, sent);
        chk({name, "_sent"}, sent, 32);
        engine(nwr, lwd, gd);
        n = 0;
        while (req_done == 2'b00 && n < 2000) begin tick(); n++; end
        if (exp_wait >= 0) chk({name, "_waitcyc"}, n, exp_wait);
        chk({name, "_done"}, req_done, exp_g);
        chk({name, "_err"}, err_code, exp_err);
        tick();
        chk({name, "_donepulse"}, req_done, 2'b00);
        chk({name, "_idlebusy"}, busy, 1'b0);
        chk({name, "_idlegrant"}, req_grant, 2'b00);
        chk({name, "_errhold"}, err_code, exp_err);
        chk({name, "_nstart"}, starts - st0, 1);
        chk({name, "_ndone"}, dones - dn0, 1);
        got = rx_q.size() - base;
        chk({name, "_rxcount"}, got, 32);
        for (int i = 0; i < got && i < 32; i++) begin
            if (rx_q[base + i] !== pat(src, i + 1)) bad++;
        end
        chk({name, "_rxdata"}, bad, 0);
`ifdef SCHED_PERF_EN
        chk({name, "_perf"}, perf_cycles, busy_cyc - bz0);
`else
        chk({name, "_perf"}, perf_cycles, 32'd0);
`endif
        req_valid = '0;
        $display("job %s: grant=%b err=%b beats=%0d latency=%0d", name, exp_g, err_code, got, busy_cyc - bz0);
    endtask

    initial begin
        int sent = 0;
        int dn0 = 0;
        // Power-on reset.
        tick();
        tick();
        chk("rst_grant", req_grant, 2'b00);
        chk("rst_start", ap_start_matmul, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_code, 3'b000);
        chk("rst_perf", perf_cycles, 32'd0);
        chk("rst_mvalid", m_tvalid, 1'b0);
        rst = 1'b0;
        tick();

        // Single requester 0, clean job.
        run_job("nominal", 2'b01, 0, 32, 0, 0, 16, 0, 1, 3'b000, 0);

        // Reset the pointer, then both requesters held for three jobs.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        run_job("rr1", 2'b11, 0, 32, 0, 0, 16, 0, 1, 3'b000, 0);
        run_job("rr2", 2'b11, 1, 32, 0, 0, 16, 0, 1, 3'b000, 0);
        run_job("rr3", 2'b11, 0, 32, 0, 0, 16, 0, 1, 3'b000, 0);
        chk("rr_onehot", multi, 0);

        // Bubbles on both sides; 16th write arrives together with done.
        run_job("stall", 2'b10, 1, 32, 1, 1, 16, 1, 1, 3'b000, 0);

        // Early tlast on beat 20: transfer still runs to 32 beats.
        run_job("tlast20", 2'b01, 0, 20, 0, 0, 16, 0, 1, 3'b001, 0);

        // Short on result writes; also shows err_code cleared at grant.
        run_job("short_wr", 2'b10, 1, 32, 0, 0, 15, 0, 1, 3'b010, 0);

        // Engine never finishes.
        run_job("timeout", 2'b01, 0, 32, 0, 0, 0, 0, 0, 3'b100, 1024);

        // Engine strobes in IDLE are ignored.
        dn0 = dones;
        done_matmul = 1'b1; w_fifo_en = 1'b1; tick();
        done_matmul = 1'b0; w_fifo_en = 1'b0; tick();
        chk("idle_strobe_done", dones - dn0, 0);
        chk("idle_strobe_busy", busy, 1'b0);

        // Reset during FEED after 10 beats abandons the job.
        dn0 = dones;
        req_valid = 2'b01;
        tick();
        feed(0, 10, 32, 0, 0, sent);
        chk("midrst_sent", sent, 10);
        s_tvalid = 2'b01;
        rst = 1'b1;
        #1;
        chk("midrst_grant", req_grant, 2'b00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_tready", s_tready, 2'b00);
        chk("midrst_mvalid", m_tvalid, 1'b0);
        chk("midrst_mdata", m_tdata, 32'd0);
        chk("midrst_err", err_code, 3'b000);
        chk("midrst_perf", perf_cycles, 32'd0);
        req_valid = '0;
        s_tvalid = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("midrst_nodone", dones - dn0, 0);
        tick();
        run_job("after_rst", 2'b10, 1, 32, 0, 0, 16, 0, 1, 3'b000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if something stalls far beyond any job length.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
